// File: rtl/df_pkg.sv
// Shared types and helpers for the digital-filter digit-serial arithmetic blocks.
package df_pkg;

  typedef enum logic {
    DF_IDLE = 1'b0,
    DF_RUN  = 1'b1
  } df_state_e;

  // Counter width for n states; never narrower than one bit so N=1 still has a register.
  function automatic int df_cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/df_digit_adder.sv
// DIGIT-bit combinational ripple adder slice; exposes the carry into its top bit for overflow.
module df_digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co    = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/df_digit_serial_adder.sv
// Digit-serial add/subtract: LSB digit first, one DIGIT slice per clock, carry held between digits.
module df_digit_serial_adder
  import df_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = df_cnt_w(N);

  df_state_e        state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr, a_nx, b_nx, r_nx;
  logic [CW-1:0]    cnt;
  logic             carry, load, last;
  logic [DIGIT-1:0] dsum;
  logic             dco, dmsb;

  always_ff @(posedge clk) begin
    if (rst) state <= DF_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      DF_IDLE: if (start) state_nx = DF_RUN;
      DF_RUN:  if (cnt == CW'(N - 1)) state_nx = DF_IDLE;
      default: state_nx = DF_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == DF_RUN);
    load = (state == DF_IDLE) && start;
    last = (state == DF_RUN) && (cnt == CW'(N - 1));
  end

  df_digit_adder #(.DIGIT(DIGIT)) u_dig (
    .a     (a_sr[DIGIT-1:0]),
    .b     (b_sr[DIGIT-1:0]),
    .ci    (carry),
    .s     (dsum),
    .co    (dco),
    .c_msb (dmsb)
  );

  generate
    if (N == 1) begin : g_single
      assign a_nx = a_sr;
      assign b_nx = b_sr;
      assign r_nx = dsum;
    end else begin : g_multi
      // Partial result fills from the top; the final digit completes it in r_nx.
      logic [WIDTH-DIGIT-1:0] r_sr;
      assign a_nx = {{DIGIT{1'b0}}, a_sr[WIDTH-1:DIGIT]};
      assign b_nx = {{DIGIT{1'b0}}, b_sr[WIDTH-1:DIGIT]};
      assign r_nx = {dsum, r_sr};
      always_ff @(posedge clk) begin
        if (rst)       r_sr <= '0;
        else if (busy) r_sr <= r_nx[WIDTH-1:DIGIT];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      done  <= 1'b0;
      s     <= '0;
      co    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= last;
      if (load) begin
        // Subtraction as a + ~b + 1: invert B once, seed the carry with 1.
        a_sr  <= a;
        b_sr  <= b ^ {WIDTH{sub}};
        carry <= sub;
        cnt   <= '0;
      end else if (busy) begin
        a_sr  <= a_nx;
        b_sr  <= b_nx;
        carry <= dco;
        cnt   <= cnt + CW'(1);
      end
      if (last) begin
        s   <= r_nx;
        co  <= dco;
        ovf <= dmsb ^ dco;
      end
    end
  end

endmodule

// File: tb/tb_df_digit_serial_adder.sv
// Bench for df_digit_serial_adder: three instances (DIGIT 1/4/16) against an integer reference model.
module tb_df_digit_serial_adder;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [2:0]   start = '0, sub = '0;
  logic [2:0]   busy, done, co, ovf;
  logic [W-1:0] a [3];
  logic [W-1:0] b [3];
  logic [W-1:0] s [3];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    df_digit_serial_adder #(.WIDTH(W), .DIGIT(g == 0 ? 1 : (g == 1 ? 4 : 16))) u_dut (
      .clk   (clk),
      .rst   (rst),
      .start (start[g]),
      .sub   (sub[g]),
      .a     (a[g]),
      .b     (b[g]),
      .busy  (busy[g]),
      .done  (done[g]),
      .s     (s[g]),
      .co    (co[g]),
      .ovf   (ovf[g])
    );
  end

  function automatic int dig(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 4 : 16);
  endfunction

  // Reference: integer arithmetic on the signed/unsigned views of the operands.
  function automatic void ref_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                                 output logic [W-1:0] rs, output logic rco, output logic rovf);
    int sa, sb, r, ua, ub;
    sa = $signed(av);
    sb = $signed(bv);
    ua = int'({16'h0, av});
    ub = int'({16'h0, bv});
    r  = sv ? sa - sb : sa + sb;
    rs = r[W-1:0];
    rovf = (r > 32767) || (r < -32768);
    rco  = sv ? (ua >= ub) : ((ua + ub) > 65535);
  endfunction

  // Launch one operation on instance k and return observations at the done cycle.
  task automatic run_op(input int k, input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                        output logic [W-1:0] rs, output logic rco, output logic rovf,
                        output int lat, output bit busy_ok);
    @(negedge clk);
    a[k] = av; b[k] = bv; sub[k] = sv; start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
    lat = 1;
    busy_ok = 1'b1;
    while (!done[k] && lat < 100) begin
      if (!busy[k]) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (busy[k]) busy_ok = 1'b0;
    rs = s[k]; rco = co[k]; rovf = ovf[k];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_cmp += 5;
      if (busy[k] !== 1'b0) begin n_err++; $display("FAIL reset_busy[%0d]: got %b want 0", k, busy[k]); end
      if (done[k] !== 1'b0) begin n_err++; $display("FAIL reset_done[%0d]: got %b want 0", k, done[k]); end
      if (s[k] !== 16'h0)   begin n_err++; $display("FAIL reset_s[%0d]: got %h want 0000", k, s[k]); end
      if (co[k] !== 1'b0)   begin n_err++; $display("FAIL reset_co[%0d]: got %b want 0", k, co[k]); end
      if (ovf[k] !== 1'b0)  begin n_err++; $display("FAIL reset_ovf[%0d]: got %b want 0", k, ovf[k]); end
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [5] = '{16'h1234, 16'h7FFF, 16'hFFFF, 16'h0000, 16'h8000};
    logic [W-1:0] tb [5] = '{16'h4321, 16'h0001, 16'h0001, 16'h0001, 16'h0001};
    logic         tsb[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] ts [5] = '{16'h5555, 16'h8000, 16'h0000, 16'hFFFF, 16'h7FFF};
    logic         tco[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic         tov[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] rs; logic rco, rovf; int lat; bit bok;
    for (int i = 0; i < 5; i++) begin
      run_op(1, ta[i], tb[i], tsb[i], rs, rco, rovf, lat, bok);
      n_cmp += 5;
      if (rs !== ts[i])   begin n_err++; $display("FAIL directed[%0d]_s: got %h want %h", i, rs, ts[i]); end
      if (rco !== tco[i]) begin n_err++; $display("FAIL directed[%0d]_co: got %b want %b", i, rco, tco[i]); end
      if (rovf !== tov[i]) begin n_err++; $display("FAIL directed[%0d]_ovf: got %b want %b", i, rovf, tov[i]); end
      if (lat != 5)       begin n_err++; $display("FAIL directed[%0d]_latency: got %0d want 5", i, lat); end
      if (!bok)           begin n_err++; $display("FAIL directed[%0d]_busy: busy not high for cycles 1-4 only", i); end
    end
  endtask

  task automatic test_busy_ignore();
    logic [W-1:0] prev; int lat; bit stable;
    @(negedge clk);
    prev = s[1];
    a[1] = 16'h1234; b[1] = 16'h4321; sub[1] = 1'b0; start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    lat = 1; stable = 1'b1;
    while (!done[1] && lat < 100) begin
      if (s[1] !== prev) stable = 1'b0;
      if (lat == 2) begin a[1] = 16'hFFFF; b[1] = 16'h0F0F; sub[1] = 1'b1; start[1] = 1'b1; end
      else start[1] = 1'b0;
      @(negedge clk);
      lat++;
    end
    start[1] = 1'b0;
    n_cmp += 4;
    if (s[1] !== 16'h5555) begin n_err++; $display("FAIL busy_ignore_s: got %h want 5555", s[1]); end
    if (co[1] !== 1'b0)    begin n_err++; $display("FAIL busy_ignore_co: got %b want 0", co[1]); end
    if (lat != 5)          begin n_err++; $display("FAIL busy_ignore_latency: got %0d want 5", lat); end
    if (!stable)           begin n_err++; $display("FAIL busy_ignore_s_stable: s changed while busy (prev %h)", prev); end
    @(negedge clk);
    n_cmp++;
    if (busy[1] !== 1'b0) begin n_err++; $display("FAIL busy_ignore_restart: got busy %b want 0", busy[1]); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] rs, es; logic rco, rovf, eco, eov; int lat; bit bok;
    run_op(1, 16'hA5A5, 16'h1111, 1'b0, rs, rco, rovf, lat, bok);
    n_cmp++;
    if (rs !== 16'hB6B6) begin n_err++; $display("FAIL b2b_first_s: got %h want b6b6", rs); end
    // Still in the done cycle: launch the second operation now.
    a[1] = 16'h0100; b[1] = 16'h0200; sub[1] = 1'b1; start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    n_cmp += 2;
    if (busy[1] !== 1'b1) begin n_err++; $display("FAIL b2b_busy: got %b want 1", busy[1]); end
    if (done[1] !== 1'b0) begin n_err++; $display("FAIL b2b_done_low: got %b want 0", done[1]); end
    lat = 1;
    while (!done[1] && lat < 100) begin @(negedge clk); lat++; end
    ref_op(16'h0100, 16'h0200, 1'b1, es, eco, eov);
    n_cmp += 4;
    if (lat != 5)       begin n_err++; $display("FAIL b2b_latency: got %0d want 5", lat); end
    if (s[1] !== es)    begin n_err++; $display("FAIL b2b_second_s: got %h want %h", s[1], es); end
    if (co[1] !== eco)  begin n_err++; $display("FAIL b2b_second_co: got %b want %b", co[1], eco); end
    if (ovf[1] !== eov) begin n_err++; $display("FAIL b2b_second_ovf: got %b want %b", ovf[1], eov); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] rs, es; logic rco, rovf, eco, eov; int lat; bit bok, saw_done;
    @(negedge clk);
    a[1] = 16'h2222; b[1] = 16'h3333; sub[1] = 1'b0; start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp += 3;
    if (busy[1] !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b want 0", busy[1]); end
    if (s[1] !== 16'h0)   begin n_err++; $display("FAIL rst_mid_s: got %h want 0000", s[1]); end
    if (done[1] !== 1'b0) begin n_err++; $display("FAIL rst_mid_done: got %b want 0", done[1]); end
    saw_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done[1]) saw_done = 1'b1;
    end
    n_cmp++;
    if (saw_done) begin n_err++; $display("FAIL rst_mid_no_done: got done pulse want none"); end
    run_op(1, 16'h4000, 16'h4000, 1'b0, rs, rco, rovf, lat, bok);
    ref_op(16'h4000, 16'h4000, 1'b0, es, eco, eov);
    n_cmp += 3;
    if (rs !== es || rco !== eco || rovf !== eov)
      begin n_err++; $display("FAIL rst_mid_fresh: got %h/%b/%b want %h/%b/%b", rs, rco, rovf, es, eco, eov); end
    if (lat != 5) begin n_err++; $display("FAIL rst_mid_fresh_latency: got %0d want 5", lat); end
    if (!bok)     begin n_err++; $display("FAIL rst_mid_fresh_busy: busy window wrong"); end
  endtask

  task automatic test_sweep();
    logic [W-1:0] av, bv, rs, es; logic sv, rco, rovf, eco, eov; int lat; bit bok;
    logic [W-1:0] edges [4] = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF};
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 25; i++) begin
        av = (i % 5 == 0) ? edges[$urandom_range(3)] : W'($urandom);
        bv = (i % 7 == 0) ? edges[$urandom_range(3)] : W'($urandom);
        sv = 1'($urandom);
        run_op(k, av, bv, sv, rs, rco, rovf, lat, bok);
        ref_op(av, bv, sv, es, eco, eov);
        n_cmp += 5;
        if (rs !== es)    begin n_err++; $display("FAIL sweep_d%0d_s: %h %s %h got %h want %h", dig(k), av, sv ? "-" : "+", bv, rs, es); end
        if (rco !== eco)  begin n_err++; $display("FAIL sweep_d%0d_co: %h %s %h got %b want %b", dig(k), av, sv ? "-" : "+", bv, rco, eco); end
        if (rovf !== eov) begin n_err++; $display("FAIL sweep_d%0d_ovf: %h %s %h got %b want %b", dig(k), av, sv ? "-" : "+", bv, rovf, eov); end
        if (lat != W / dig(k) + 1) begin n_err++; $display("FAIL sweep_d%0d_latency: got %0d want %0d", dig(k), lat, W / dig(k) + 1); end
        if (!bok) begin n_err++; $display("FAIL sweep_d%0d_busy: busy window wrong", dig(k)); end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin a[k] = '0; b[k] = '0; end
    test_reset();
    test_directed();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
